// File: rtl/frame_pixel_responder.sv
// Framebuffer-side responder for the gray-scale pixel stream: serves one FIFO pixel
// per next-pixel strobe edge and restarts the frame on a frame-reset strobe edge.
module frame_pixel_responder #(
    parameter int                DATA_W       = 4,
    parameter int                DEPTH        = 16,
    parameter int                FRAME_PIXELS = 307200,
    parameter int                CNT_W        = 19,
    parameter logic [DATA_W-1:0] UNDERRUN_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       next_pixel_in,
    input  logic                       frame_reset_in,
    output logic [DATA_W-1:0]          pixel_out,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       underrun,
    output logic                       overrun
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic                np_prev_q, fr_prev_q;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   pixel_q, pixel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                frame_start_q, frame_start_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic np_edge, fr_edge, full, empty, push, pop;

    always_comb begin
        np_edge  = next_pixel_in & ~np_prev_q;
        fr_edge  = frame_reset_in & ~fr_prev_q;
        full     = (fill_q == FILL_W'(DEPTH));
        empty    = (fill_q == '0);
        wr_ready = ~full & ~fr_edge;
        push     = wr_valid & wr_ready;
        cnt_inc  = cnt_q + CNT_W'(1);

        state_d       = state_q;
        pixel_d       = pixel_q;
        cnt_d         = cnt_q;
        underrun_d    = underrun_q;
        overrun_d     = overrun_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        pop           = 1'b0;

        // Frame reset wins over a coincident pixel request, which is dropped.
        if (fr_edge) begin
            state_d       = STREAM;
            cnt_d         = '0;
            pixel_d       = UNDERRUN_VAL;
            frame_start_d = 1'b1;
            underrun_d    = 1'b0;
            overrun_d     = 1'b0;
        end else if (np_edge) begin
            case (state_q)
                STREAM: begin
                    if (!empty) begin
                        pixel_d = mem_q[rd_ptr_q];
                        pop     = 1'b1;
                    end else begin
                        pixel_d    = UNDERRUN_VAL;
                        underrun_d = 1'b1;
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(FRAME_PIXELS)) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end
                end
                DONE: begin
                    pixel_d   = UNDERRUN_VAL;
                    overrun_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (fr_edge) begin
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
            fill_d   = '0;
        end else begin
            rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            fill_d   = fill_q + FILL_W'(push) - FILL_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            np_prev_q     <= 1'b0;
            fr_prev_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fill_q        <= '0;
            pixel_q       <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            np_prev_q     <= next_pixel_in;
            fr_prev_q     <= frame_reset_in;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
            pixel_q       <= pixel_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign pixel_out   = pixel_q;
    assign fill_level  = fill_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
endmodule
